// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use and control hazards,
// EX forwarding, and a memory-wait freeze FSM with timeout and perf counters.
module hazard_ctrl #(
   parameter int REG_WIDTH = 5,
   parameter int CNT_WIDTH = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_WIDTH-1:0] rs1_d,
   input  logic [REG_WIDTH-1:0] rs2_d,
   input  logic [REG_WIDTH-1:0] rs1_e,
   input  logic [REG_WIDTH-1:0] rs2_e,
   input  logic [REG_WIDTH-1:0] rd_e,
   input  logic [1:0]           result_src_e,
   input  logic                 pc_src_e,
   input  logic [REG_WIDTH-1:0] rd_m,
   input  logic [REG_WIDTH-1:0] rd_w,
   input  logic                 reg_write_m,
   input  logic                 reg_write_w,
   input  logic                 mem_req_m,
   input  logic                 mem_ready,
   input  logic                 cnt_clr,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_w,
   output logic [1:0]           fwd_a_e,
   output logic [1:0]           fwd_b_e,
   output logic                 mem_timeout,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            mem_stall;
   logic            lw_stall;
   logic [1:0]      fwd_a, fwd_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_stall = 1'b0;
      unique case (state_q)
         RUN: begin
            if (mem_req_m && !mem_ready) begin
               state_d   = MEM_WAIT;
               wait_d    = WW'(1);
               mem_stall = 1'b1;
            end else begin
               wait_d = '0;
            end
         end
         MEM_WAIT: begin
            mem_stall = !mem_ready;
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
               state_d = ERROR;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         ERROR: mem_stall = 1'b1;
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   assign lw_stall = (result_src_e == 2'b01) && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

   // MEM result is younger than WB, so it takes priority
   assign fwd_a = (reg_write_m && rd_m != '0 && rd_m == rs1_e) ? 2'b10 :
                  (reg_write_w && rd_w != '0 && rd_w == rs1_e) ? 2'b01 :
                  2'b00;
   assign fwd_b = (reg_write_m && rd_m != '0 && rd_m == rs2_e) ? 2'b10 :
                  (reg_write_w && rd_w != '0 && rd_w == rs2_e) ? 2'b01 :
                  2'b00;

   // Reset forces every control output low without waiting for a clock
   assign stall_f = rst && (lw_stall || mem_stall);
   assign stall_d = stall_f;
   assign stall_e = rst && mem_stall;
   assign stall_m = stall_e;
   assign flush_w = stall_e;
   assign flush_d = rst && pc_src_e && !mem_stall;
   assign flush_e = rst && (lw_stall || pc_src_e) && !mem_stall;
   assign fwd_a_e = rst ? fwd_a : 2'b00;
   assign fwd_b_e = rst ? fwd_b : 2'b00;

   assign mem_timeout = (state_q == ERROR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_d && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         if (flush_e && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and 4-bit counters.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0] result_src_e;
   logic       pc_src_e, reg_write_m, reg_write_w;
   logic       mem_req_m, mem_ready, cnt_clr;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w;
   logic [1:0] fwd_a_e, fwd_b_e;
   logic       mem_timeout;
   logic [3:0] stall_cnt, flush_cnt;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_WIDTH (5),
      .CNT_WIDTH (4),
      .TIMEOUT   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rs1_e        (rs1_e),
      .rs2_e        (rs2_e),
      .rd_e         (rd_e),
      .result_src_e (result_src_e),
      .pc_src_e     (pc_src_e),
      .rd_m         (rd_m),
      .rd_w         (rd_w),
      .reg_write_m  (reg_write_m),
      .reg_write_w  (reg_write_w),
      .mem_req_m    (mem_req_m),
      .mem_ready    (mem_ready),
      .cnt_clr      (cnt_clr),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_w      (flush_w),
      .fwd_a_e      (fwd_a_e),
      .fwd_b_e      (fwd_b_e),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
      rd_e = 0; rd_m = 0; rd_w = 0;
      result_src_e = 2'b00;
      pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
      mem_req_m = 0; mem_ready = 0; cnt_clr = 0;
   endtask

   // pack of {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}
   function automatic logic [6:0] ctl();
      return {stall_f, stall_d, stall_e, stall_m,
              flush_d, flush_e, flush_w};
   endfunction

   initial begin
      clr_in();
      rst = 1'b0;
      #3;
      chk("rst_ctl", 32'(ctl()), 32'h0);
      chk("rst_fwd", {fwd_a_e, fwd_b_e}, 32'h0);
      chk("rst_to", 32'(mem_timeout), 32'h0);
      chk("rst_cnt", {stall_cnt, flush_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // load-use
      result_src_e = 2'b01; rd_e = 5; rs1_d = 5;
      #1 chk("lu_ctl", 32'(ctl()), 32'b1100010);
      @(negedge clk);
      rd_e = 0; rs1_d = 0; rs2_d = 0;
      #1 chk("lu_x0", 32'(ctl()), 32'h0);
      @(negedge clk);
      clr_in();

      // forwarding priority
      rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 7;
      reg_write_m = 1; reg_write_w = 1;
      #1 chk("fwd_mem", {fwd_a_e, fwd_b_e}, 32'b1010);
      reg_write_m = 0;
      #1 chk("fwd_wb", {fwd_a_e, fwd_b_e}, 32'b0101);
      rs2_e = 3;
      #1 chk("fwd_mix", {fwd_a_e, fwd_b_e}, 32'b0100);
      reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
      #1 chk("fwd_x0", {fwd_a_e, fwd_b_e}, 32'b0000);
      @(negedge clk);
      clr_in();

      // branch
      pc_src_e = 1;
      #1 chk("br_ctl", 32'(ctl()), 32'b0000110);
      @(negedge clk);
      clr_in();
      #1 chk("br_cnt", {stall_cnt, flush_cnt}, 32'h12);

      // memory wait 3 cycles then ready, branch held in EX
      mem_req_m = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         pc_src_e = (i == 2);
         #1 chk("mw_ctl", 32'(ctl()), 32'b1111001);
         @(negedge clk);
      end
      mem_ready = 1; pc_src_e = 1;
      #1 chk("mw_rdy", 32'(ctl()), 32'b0000110);
      @(negedge clk);
      clr_in();
      #1 chk("mw_cnt", {stall_cnt, flush_cnt}, 32'h43);

      // counter saturation then clear
      result_src_e = 2'b01; rd_e = 9; rs2_d = 9;
      repeat (20) @(negedge clk);
      #1 chk("sat_cnt", {stall_cnt, flush_cnt}, 32'hff);
      cnt_clr = 1;
      @(negedge clk);
      #1 chk("clr_cnt", {stall_cnt, flush_cnt}, 32'h00);
      cnt_clr = 0;
      @(negedge clk);
      #1 chk("post_clr", {stall_cnt, flush_cnt}, 32'h11);
      clr_in();

      // timeout
      mem_req_m = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("to_wait", {31'(stall_e), mem_timeout}, 32'b10);
         @(negedge clk);
      end
      #1 chk("to_set", {31'(stall_e), mem_timeout}, 32'b11);
      @(negedge clk);
      mem_req_m = 0; mem_ready = 1;
      rd_m = 7; rs1_e = 7; reg_write_m = 1;
      #1 chk("to_stick", {31'(stall_d), mem_timeout}, 32'b11);
      chk("to_fwd", 32'(fwd_a_e), 32'b10);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("to_rst", {25'(ctl()), mem_timeout}, 32'h0);
      chk("to_rcnt", {stall_cnt, flush_cnt}, 32'h0);
      @(negedge clk);
      clr_in();
      rst = 1'b1;
      @(negedge clk);
      #1 chk("to_run", {25'(ctl()), mem_timeout}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
